hs_src_feeder: RTL and testbench



---
 rtl/hs_pkg.sv | 15 +
 rtl/hs_src_feeder_if.sv | 34 +++
 rtl/sync_fifo_sclk.sv | 66 ++++++
 rtl/hs_src_feeder.sv | 78 +++++++
 tb/tb_hs_src_feeder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the handshake synchronizer source/destination slice.
// FSM encoding, default word width and a pointer-width helper.
package hs_pkg;

  localparam int HS_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hs_src_feeder_if.sv
// Upstream stream plus synchronizer source port of the sclk-side feeder.
// master drives words and sidle, slave is the feeder.
interface hs_src_feeder_if
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sidle;
  logic             sready;
  logic [WIDTH-1:0] din;

  modport master (
    output in_valid,
    output in_data,
    output sidle,
    input  in_ready,
    input  sready,
    input  din
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  sidle,
    output in_ready,
    output sready,
    output din
  );

endinterface

// File: rtl/sync_fifo_sclk.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Head word is presented combinationally; no fall-through from push.
module sync_fifo_sclk
  import hs_pkg::*;
#(
  parameter  int WIDTH = HS_WIDTH,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + (PW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count <= count - (PW + 1)'(1);
    end
  end

endmodule

// File: rtl/hs_src_feeder.sv
// sclk-side transmitter: buffers upstream words and issues each one
// exactly once into the handshake synchronizer source port.
module hs_src_feeder
  import hs_pkg::*;
#(
  parameter  int WIDTH = HS_WIDTH,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic             sclk,
  input  logic             rst_n,
  hs_src_feeder_if.slave   bus,
  output logic [PW:0]      fifo_cnt,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             busy
);

  logic [1:0]       state;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = (state == ST_IDLE) && !empty && bus.sidle;
  assign busy         = (state != ST_IDLE) || !empty;

  sync_fifo_sclk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.in_data),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (full),
    .empty (empty)
  );

  // BUSY leaves on any sidle, so an early idle cannot lock the FSM
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bus.sready <= 1'b0;
      bus.din    <= '0;
      sent_cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (pop) begin
            bus.din    <= head;
            bus.sready <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        (state == ST_ISSUE): begin
          bus.sready <= 1'b0;
          sent_cnt   <= sent_cnt + CNT_W'(1);
          state      <= ST_BUSY;
        end
        (state == ST_BUSY): begin
          if (bus.sidle) state <= ST_IDLE;
        end
        default: begin
          bus.sready <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_src_feeder.sv
// Bench for hs_src_feeder: queue-based model, per-cycle compare,
// directed literal checks and a behavioural synchronizer responder.
module tb_hs_src_feeder;
  import hs_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  hs_src_feeder_if #(.WIDTH(W)) bus ();
  hs_src_feeder_if #(.WIDTH(W)) bus2 ();

  logic [2:0]  fifo_cnt, fifo_cnt2;
  logic [15:0] sent_cnt;
  logic [3:0]  sent_cnt2;
  logic        busy, busy2;

  hs_src_feeder #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .fifo_cnt (fifo_cnt),
    .sent_cnt (sent_cnt),
    .busy     (busy)
  );

  hs_src_feeder #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut_w4 (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .bus      (bus2.slave),
    .fifo_cnt (fifo_cnt2),
    .sent_cnt (sent_cnt2),
    .busy     (busy2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // synchronizer responder: sidle low for hold_len cycles after sampling sready
  logic       force_low = 1'b0;
  int         hold_len  = 10;
  int         hold_cnt  = 0;
  logic [7:0] got[$];
  logic [7:0] pushed[$];

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 0;
    end else if (bus.sready) begin
      hold_cnt <= hold_len;
      got.push_back(bus.din);
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
    end
  end

  assign bus.sidle      = !force_low && (hold_cnt == 0);
  assign bus2.sidle     = bus.sidle;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;

  // model: FIFO as a queue, one word in flight until the handshake closes
  logic [7:0] q[$];
  int         m_sent     = 0;
  bit         m_inflight = 0;
  int         m_age      = 0;
  bit         m_sready   = 0;
  logic [7:0] m_din      = '0;

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_sent     = 0;
      m_inflight = 0;
      m_age      = 0;
      m_sready   = 0;
      m_din      = '0;
    end else begin
      bit can_push;
      bit go;
      can_push = q.size() < D;
      go       = !m_inflight && q.size() > 0 && bus.sidle;
      if (m_sready) begin
        m_sent++;
        m_sready = 0;
      end
      if (m_inflight) begin
        if (m_age >= 1 && bus.sidle) m_inflight = 0;
        else m_age++;
      end
      if (go) begin
        m_din      = q.pop_front();
        m_sready   = 1;
        m_inflight = 1;
        m_age      = 0;
      end
      if (bus.in_valid && can_push) q.push_back(bus.in_data);
    end
  end

  always @(negedge sclk) begin
    chk("sready", bus.sready, m_sready);
    chk("din", bus.din, m_din);
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("sent_cnt", sent_cnt, m_sent % 65536);
    chk("busy", busy, m_inflight || q.size() != 0);
    chk("in_ready", bus.in_ready, q.size() != D);
    chk("sent_cnt_w4", sent_cnt2, m_sent % 16);
    chk("sready_w4", bus2.sready, m_sready);
    chk("din_w4", bus2.din, m_din);
    chk("sready_vs_sidle", bus.sready && !bus.sidle, 0);
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    chk("push_timeout", n >= 200, 0);
    step();
    bus.in_valid = 1'b0;
    if (n < 200) pushed.push_back(d);
  endtask

  task automatic wait_quiet(input int bound);
    int n;
    n = 0;
    while ((busy || !bus.sidle) && n < bound) begin
      step();
      n++;
    end
    chk("quiet_timeout", n >= bound, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int gsize;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) step();
    chk("rst_sready", bus.sready, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_sent_cnt", sent_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // single word
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    pushed.push_back(8'hA5);
    chk("one_cnt_after_push", fifo_cnt, 1);
    chk("one_no_fallthrough", bus.sready, 0);
    step();
    chk("one_sready", bus.sready, 1);
    chk("one_din", bus.din, 8'hA5);
    chk("one_cnt_after_pop", fifo_cnt, 0);
    step();
    chk("one_sready_drop", bus.sready, 0);
    chk("one_sent", sent_cnt, 1);
    chk("one_busy", busy, 1);
    repeat (12) step();
    chk("one_no_second", sent_cnt, 1);
    chk("one_din_held", bus.din, 8'hA5);
    wait_quiet(100);

    // burst fill with sidle held low
    force_low = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    repeat (3) step();
    chk("full_cnt", fifo_cnt, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_no_issue", bus.sready, 0);
    hold_len  = 4;
    force_low = 1'b0;
    step();
    chk("full_issue", bus.sready, 1);
    chk("full_issue_din", bus.din, 8'h01);
    chk("full_pop_no_push", fifo_cnt, 3);
    step();
    chk("full_refill", fifo_cnt, 4);
    pushed.push_back(8'h05);
    push_word(8'h06);
    wait_quiet(400);

    // same-edge push/pop, and sidle never dropping
    hold_len     = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    step();
    bus.in_data = 8'hC3;
    step();
    bus.in_valid = 1'b0;
    pushed.push_back(8'h3C);
    pushed.push_back(8'hC3);
    chk("pp_cnt_same", fifo_cnt, 1);
    chk("pp_sready", bus.sready, 1);
    chk("pp_din", bus.din, 8'h3C);
    repeat (3) step();
    chk("perr_reissue", bus.sready, 1);
    chk("perr_din", bus.din, 8'hC3);
    wait_quiet(100);

    // closed loop, random words and round-trip lengths
    for (int i = 0; i < 50; i++) begin
      hold_len = $urandom_range(2, 8);
      push_word(8'($urandom));
    end
    wait_quiet(2000);
    chk("total_sent", sent_cnt, 59);
    chk("wrap_sent_w4", sent_cnt2, 11);
    chk("issued_count", got.size(), pushed.size());
    bad = 0;
    for (int i = 0; i < got.size() && i < pushed.size(); i++)
      if (got[i] !== pushed[i]) bad++;
    chk("issued_order", bad, 0);

    // async reset in BUSY with words buffered
    hold_len = 20;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    repeat (2) step();
    chk("mid_cnt", fifo_cnt, 3);
    chk("mid_busy", busy, 1);
    gsize = got.size();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sready", bus.sready, 0);
    chk("arst_din", bus.din, 0);
    chk("arst_cnt", fifo_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    step();
    rst_n = 1'b1;
    repeat (25) step();
    chk("no_stale_issue", got.size(), gsize);
    chk("post_rst_sent", sent_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
